// File: rtl/ps2_command_tx_if.sv
// Command handshake and completion status between a host controller and ps2_command_tx.
interface ps2_command_tx_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err;
    logic       timeout;

    modport master (
        output cmd_data, cmd_valid,
        input  cmd_ready, busy, done, ack_ok, err, timeout
    );

    modport slave (
        input  cmd_data, cmd_valid,
        output cmd_ready, busy, done, ack_ok, err, timeout
    );
endinterface

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one odd-parity command byte
// on device-generated clocks, then reports ACK, NACK or timeout with a one-cycle done pulse.
module ps2_command_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned SETUP_CYCLES   = 250,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic            CLOCK_50,
    input  logic            reset_n,
    ps2_command_tx_if.slave cmd_if,
    input  logic            ps2_clk_in,
    input  logic            ps2_dat_in,
    output logic            ps2_clk_oe,
    output logic            ps2_dat_oe
);
    localparam int unsigned PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int unsigned PH_W      = $clog2(PHASE_MAX + 1);
    localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BIT_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_WAIT_ACK, S_WAIT_IDLE, S_DONE
    } state_t;

    state_t             r_state,   w_state;
    logic               r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
    logic [7:0]         r_data,    w_data;
    logic               r_parity,  w_parity;
    logic [PH_W-1:0]    r_ph_cnt,  w_ph_cnt;
    logic [TO_W-1:0]    r_to_cnt,  w_to_cnt;
    logic [BIT_W-1:0]   r_bit_idx, w_bit_idx;
    logic               r_clk_oe,  w_clk_oe;
    logic               r_dat_oe,  w_dat_oe;
    logic               r_ready,   w_ready;
    logic               r_busy,    w_busy;
    logic               r_done,    w_done;
    logic               r_ack_ok,  w_ack_ok;
    logic               r_err,     w_err;
    logic               r_timeout, w_timeout;
    logic               w_fe;
    logic [TO_W-1:0]    w_to_inc;
    logic               w_to_expire;

    assign w_fe        = r_clk_prev & ~r_clk_s2;
    // Saturating increment; expiry is the cycle the counter would reach TIMEOUT_CYCLES.
    assign w_to_inc    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) ? r_to_cnt : r_to_cnt + TO_W'(1);
    assign w_to_expire = (w_to_inc == TO_W'(TIMEOUT_CYCLES));

    // State, synchronizer and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_ph_cnt   <= '0;
            r_to_cnt   <= '0;
            r_bit_idx  <= '0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_dat_in;
            r_dat_s2   <= r_dat_s1;
            r_data     <= w_data;
            r_parity   <= w_parity;
            r_ph_cnt   <= w_ph_cnt;
            r_to_cnt   <= w_to_cnt;
            r_bit_idx  <= w_bit_idx;
            r_clk_oe   <= w_clk_oe;
            r_dat_oe   <= w_dat_oe;
            r_ready    <= w_ready;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_ack_ok   <= w_ack_ok;
            r_err      <= w_err;
            r_timeout  <= w_timeout;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state   = r_state;
        w_data    = r_data;
        w_parity  = r_parity;
        w_ph_cnt  = r_ph_cnt;
        w_to_cnt  = r_to_cnt;
        w_bit_idx = r_bit_idx;
        w_clk_oe  = r_clk_oe;
        w_dat_oe  = r_dat_oe;
        w_done    = 1'b0;
        w_ack_ok  = r_ack_ok;
        w_err     = r_err;
        w_timeout = r_timeout;

        case (r_state)
            S_IDLE: begin
                w_clk_oe  = 1'b0;
                w_dat_oe  = 1'b0;
                w_ack_ok  = 1'b0;
                w_err     = 1'b0;
                w_timeout = 1'b0;
                w_ph_cnt  = '0;
                w_to_cnt  = '0;
                w_bit_idx = '0;
                if (cmd_if.cmd_valid && r_ready) begin
                    w_data   = cmd_if.cmd_data;
                    w_parity = ~^cmd_if.cmd_data;
                    w_clk_oe = 1'b1;
                    w_state  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_ph_cnt == PH_W'(INHIBIT_CYCLES - 1)) begin
                    w_ph_cnt = '0;
                    w_dat_oe = 1'b1;
                    w_state  = S_REQ;
                end else begin
                    w_ph_cnt = r_ph_cnt + PH_W'(1);
                end
            end
            S_REQ: begin
                if (r_ph_cnt == PH_W'(SETUP_CYCLES - 1)) begin
                    w_ph_cnt  = '0;
                    w_to_cnt  = '0;
                    w_bit_idx = '0;
                    w_clk_oe  = 1'b0;
                    w_state   = S_SEND;
                end else begin
                    w_ph_cnt = r_ph_cnt + PH_W'(1);
                end
            end
            S_SEND: begin
                if (w_fe) begin
                    w_to_cnt  = '0;
                    w_bit_idx = r_bit_idx + BIT_W'(1);
                    if (r_bit_idx < BIT_W'(8)) begin
                        w_dat_oe = ~r_data[r_bit_idx[2:0]];
                    end else if (r_bit_idx == BIT_W'(8)) begin
                        w_dat_oe = ~r_parity;
                    end else begin
                        w_dat_oe = 1'b0;
                        w_state  = S_WAIT_ACK;
                    end
                end else if (w_to_expire) begin
                    w_clk_oe  = 1'b0;
                    w_dat_oe  = 1'b0;
                    w_ack_ok  = 1'b0;
                    w_err     = 1'b1;
                    w_timeout = 1'b1;
                    w_done    = 1'b1;
                    w_state   = S_DONE;
                end else begin
                    w_to_cnt = w_to_inc;
                end
            end
            S_WAIT_ACK: begin
                if (w_fe) begin
                    w_to_cnt = '0;
                    w_ack_ok = ~r_dat_s2;
                    w_err    = r_dat_s2;
                    w_state  = S_WAIT_IDLE;
                end else if (w_to_expire) begin
                    w_clk_oe  = 1'b0;
                    w_dat_oe  = 1'b0;
                    w_ack_ok  = 1'b0;
                    w_err     = 1'b1;
                    w_timeout = 1'b1;
                    w_done    = 1'b1;
                    w_state   = S_DONE;
                end else begin
                    w_to_cnt = w_to_inc;
                end
            end
            S_WAIT_IDLE: begin
                // Device holding data low here is tolerated; only the timeout ends the wait early.
                if (r_clk_s2 && r_dat_s2) begin
                    w_done  = 1'b1;
                    w_state = S_DONE;
                end else if (w_to_expire) begin
                    w_clk_oe  = 1'b0;
                    w_dat_oe  = 1'b0;
                    w_ack_ok  = 1'b0;
                    w_err     = 1'b1;
                    w_timeout = 1'b1;
                    w_done    = 1'b1;
                    w_state   = S_DONE;
                end else begin
                    w_to_cnt = w_to_inc;
                end
            end
            S_DONE: begin
                w_clk_oe  = 1'b0;
                w_dat_oe  = 1'b0;
                w_ack_ok  = 1'b0;
                w_err     = 1'b0;
                w_timeout = 1'b0;
                w_state   = S_IDLE;
            end
            default: begin
                w_clk_oe = 1'b0;
                w_dat_oe = 1'b0;
                w_state  = S_IDLE;
            end
        endcase

        w_ready = (w_state == S_IDLE);
        w_busy  = (w_state != S_IDLE);
    end

    assign ps2_clk_oe       = r_clk_oe;
    assign ps2_dat_oe       = r_dat_oe;
    assign cmd_if.cmd_ready = r_ready;
    assign cmd_if.busy      = r_busy;
    assign cmd_if.done      = r_done;
    assign cmd_if.ack_ok    = r_ack_ok;
    assign cmd_if.err       = r_err;
    assign cmd_if.timeout   = r_timeout;
endmodule

// File: tb/tb_ps2_command_tx.sv
// Scoreboarded bench for ps2_command_tx with a PS/2 device model on open-collector lines.
module tb_ps2_command_tx;
    localparam int unsigned INH = 20;
    localparam int unsigned SET = 5;
    localparam int unsigned TO  = 100;

    logic clk = 1'b0;
    logic rst_n;
    logic bfm_clk_low = 1'b0;
    logic bfm_dat_low = 1'b0;
    logic clk_oe, dat_oe;
    logic ps2_clk_in, ps2_dat_in;

    ps2_command_tx_if cmd_if();

    // Pulled-up open-collector lines: low if either side drives.
    assign ps2_clk_in = ~(clk_oe | bfm_clk_low);
    assign ps2_dat_in = ~(dat_oe | bfm_dat_low);

    ps2_command_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50   (clk),
        .reset_n    (rst_n),
        .cmd_if     (cmd_if.slave),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (clk_oe),
        .ps2_dat_oe (dat_oe)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; bit has_frame; bit ack_ok; bit err; bit tmo; } exp_t;
    typedef struct { bit start; logic [7:0] data; bit parity; bit stop; } rx_t;

    exp_t exp_q[$];
    rx_t  rx_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    bit   bfm_fin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic bit model_parity(input logic [7:0] d);
        return (($countones(d) % 2) == 0);
    endfunction

    // mode 0 = device ACKs, 1 = device NACKs, 2 = device never clocks.
    function automatic exp_t mk(input logic [7:0] d, input int mode);
        exp_t e;
        e.data = d; e.has_frame = (mode != 2);
        e.ack_ok = (mode == 0); e.err = (mode != 0); e.tmo = (mode == 2);
        return e;
    endfunction

    // Scoreboard monitor: every done pulse consumes one expectation.
    exp_t m_e;
    rx_t  m_r;
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && cmd_if.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                m_e = exp_q.pop_front();
                chk("ack_ok", 32'(cmd_if.ack_ok), 32'(m_e.ack_ok));
                chk("err", 32'(cmd_if.err), 32'(m_e.err));
                chk("timeout", 32'(cmd_if.timeout), 32'(m_e.tmo));
                if (m_e.has_frame) begin
                    if (rx_q.size() == 0) chk("rx_missing", 0, 1);
                    else begin
                        m_r = rx_q.pop_front();
                        chk("rx_start", 32'(m_r.start), 0);
                        chk("rx_data", 32'(m_r.data), 32'(m_e.data));
                        chk("rx_parity", 32'(m_r.parity), 32'(model_parity(m_e.data)));
                        chk("rx_stop", 32'(m_r.stop), 1);
                    end
                end
            end
        end
    end

    // Inhibit/request window: clk held low INH+SET cycles, data low only in the final SET.
    int  w_c = 0, w_d = 0, w_first = -1;
    bit  w_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            w_c = 0; w_d = 0; w_first = -1; w_prev = 1'b0;
        end else begin
            if (clk_oe === 1'b1) begin
                if (dat_oe === 1'b1) begin
                    if (w_first < 0) w_first = w_c;
                    w_d++;
                end
                w_c++;
            end else if (w_prev) begin
                chk("clk_low_len", 32'(w_c), 32'(INH + SET));
                chk("dat_low_start", 32'(w_first), 32'(INH));
                chk("dat_low_len", 32'(w_d), 32'(SET));
                w_c = 0; w_d = 0; w_first = -1;
            end
            w_prev = (clk_oe === 1'b1);
        end
    end

    task automatic issue(input logic [7:0] d);
        int n = 0;
        cmd_if.cmd_data  = d;
        cmd_if.cmd_valid = 1'b1;
        while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("accept_wait", 0, 1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cmd_if.busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) chk("idle_wait", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    // Device model: clocks the frame, samples data before each rising edge, then ACK/NACK.
    task automatic device_frame(input bit nack, input int h, input int abort_at);
        int n = 0;
        bit bits[11];
        rx_t r;
        while (clk_oe !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        while (clk_oe !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin chk("bfm_request_wait", 0, 1); return; end
        bits[0] = ps2_dat_in;
        repeat (2) @(negedge clk);
        for (int p = 1; p <= 10; p++) begin
            bfm_clk_low = 1'b1;
            if (p == abort_at) begin
                repeat (3) @(negedge clk);
                rst_n = 1'b0;
                bfm_clk_low = 1'b0;
                @(negedge clk);
                chk("rst_clk_oe", 32'(clk_oe), 0);
                chk("rst_dat_oe", 32'(dat_oe), 0);
                chk("rst_busy", 32'(cmd_if.busy), 0);
                chk("rst_ready", 32'(cmd_if.cmd_ready), 1);
                rst_n = 1'b1;
                return;
            end
            repeat (h) @(negedge clk);
            bits[p] = ps2_dat_in;
            bfm_clk_low = 1'b0;
            repeat (h) @(negedge clk);
        end
        r.start = bits[0];
        for (int i = 0; i < 8; i++) r.data[i] = bits[i+1];
        r.parity = bits[9];
        r.stop   = bits[10];
        rx_q.push_back(r);
        if (!nack) bfm_dat_low = 1'b1;
        repeat (2) @(negedge clk);
        bfm_clk_low = 1'b1;
        repeat (h) @(negedge clk);
        bfm_clk_low = 1'b0;
        repeat (h) @(negedge clk);
        bfm_dat_low = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, ready_hi, d0;
        rst_n = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(cmd_if.cmd_ready), 1);
        chk("reset_busy", 32'(cmd_if.busy), 0);
        chk("reset_clk_oe", 32'(clk_oe), 0);
        chk("reset_dat_oe", 32'(dat_oe), 0);
        chk("reset_done", 32'(cmd_if.done), 0);
        chk("reset_flags", 32'({cmd_if.ack_ok, cmd_if.err, cmd_if.timeout}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        exp_q.push_back(mk(8'hED, 0));
        issue(8'hED);
        device_frame(1'b0, 8, 0);
        wait_idle();

        exp_q.push_back(mk(8'h01, 1));
        issue(8'h01);
        device_frame(1'b1, 6, 0);
        wait_idle();

        // Device silent after the request.
        exp_q.push_back(mk(8'h3C, 2));
        issue(8'h3C);
        n = 0;
        while (clk_oe === 1'b1 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (cmd_if.done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        chk("timeout_cycles", 32'(n), 32'(TO));
        chk("timeout_oe", 32'({clk_oe, dat_oe}), 0);
        wait_idle();

        // Command offered while busy must be ignored.
        exp_q.push_back(mk(8'hFF, 0));
        issue(8'hFF);
        bfm_fin = 1'b0;
        fork
            begin device_frame(1'b0, 6, 0); bfm_fin = 1'b1; end
            begin
                repeat (10) @(negedge clk);
                cmd_if.cmd_data  = 8'h55;
                cmd_if.cmd_valid = 1'b1;
                ready_hi = 0; n = 0;
                while (!bfm_fin && n < 2000) begin
                    @(negedge clk); n++;
                    if (cmd_if.cmd_ready !== 1'b0) ready_hi++;
                end
                cmd_if.cmd_valid = 1'b0;
                chk("ready_while_busy", 32'(ready_hi), 0);
            end
        join
        wait_idle();
        repeat (40) @(negedge clk);
        chk("busy_ignored_cmd", 32'(cmd_if.busy), 0);

        // Reset during the fifth falling edge, then a clean frame.
        issue(8'hA5);
        device_frame(1'b0, 7, 5);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        exp_q.push_back(mk(8'hF4, 0));
        issue(8'hF4);
        device_frame(1'b0, 8, 0);
        wait_idle();

        // Back-to-back with cmd_valid held.
        exp_q.push_back(mk(8'hED, 0));
        exp_q.push_back(mk(8'h02, 0));
        cmd_if.cmd_data  = 8'hED;
        cmd_if.cmd_valid = 1'b1;
        @(negedge clk);
        cmd_if.cmd_data  = 8'h02;
        device_frame(1'b0, 8, 0);
        n = 0;
        while (cmd_if.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("b2b_first_done", 32'(cmd_if.done), 1);
        @(negedge clk);
        chk("b2b_ready_after_done", 32'(cmd_if.cmd_ready), 1);
        @(negedge clk);
        chk("b2b_second_accept", 32'(cmd_if.busy), 1);
        cmd_if.cmd_valid = 1'b0;
        device_frame(1'b0, 8, 0);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            int mode, h;
            d    = 8'($urandom);
            mode = int'($urandom_range(0, 1));
            h    = int'($urandom_range(5, 12));
            exp_q.push_back(mk(d, mode));
            issue(d);
            device_frame(mode[0], h, 0);
            wait_idle();
        end

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("rx_q_drained", 32'(rx_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
